not_gate: RTL and testbench

NOT_GATE -- requirements
Module: not_gate

---
 rtl/not_gate.sv | 45 ++++
 tb/tb_not_gate.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/not_gate.sv
// Bitwise inverter with a combinational output, an enable-gated registered copy,
// and a saturating count of sampled input changes.
module not_gate #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] in_a_d;
    logic             changed_c;

    // Zero-latency path, deliberately outside the reset domain.
    assign out       = ~in_a;
    assign changed_c = (in_a != in_a_d);

    // Registered inverse, sticky valid flag, change detector and its counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '1;
            out_valid  <= 1'b0;
            toggle_cnt <= '0;
            in_a_d     <= '0;
        end else begin
            in_a_d <= in_a;
            if (en) begin
                out_q     <= ~in_a;
                out_valid <= 1'b1;
            end
            if (changed_c && (toggle_cnt != CNT_MAX)) begin
                toggle_cnt <= toggle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_not_gate.sv
// Directed bench for not_gate: three configurations checked against an
// abstract model every cycle, plus hand-computed literal expectations.
module tb_not_gate;

    localparam int unsigned WA = 8;
    localparam int unsigned CA = 8;
    localparam int unsigned WB = 1;
    localparam int unsigned CB = 8;
    localparam int unsigned WC = 4;
    localparam int unsigned CC = 2;

    logic clk;
    logic rst_n;
    logic en;
    logic [63:0] din [3];

    logic [WA-1:0] o_a, q_a;
    logic [WB-1:0] o_b, q_b;
    logic [WC-1:0] o_c, q_c;
    logic          v_a, v_b, v_c;
    logic [CA-1:0] t_a;
    logic [CB-1:0] t_b;
    logic [CC-1:0] t_c;

    logic [63:0] dout [3];
    logic [63:0] dq   [3];
    logic [63:0] dv   [3];
    logic [63:0] dt   [3];

    not_gate #(.WIDTH(WA), .CNT_W(CA)) u_a (
        .clk(clk), .rst_n(rst_n), .in_a(din[0][WA-1:0]), .en(en),
        .out(o_a), .out_q(q_a), .out_valid(v_a), .toggle_cnt(t_a));
    not_gate #(.WIDTH(WB), .CNT_W(CB)) u_b (
        .clk(clk), .rst_n(rst_n), .in_a(din[1][WB-1:0]), .en(en),
        .out(o_b), .out_q(q_b), .out_valid(v_b), .toggle_cnt(t_b));
    not_gate #(.WIDTH(WC), .CNT_W(CC)) u_c (
        .clk(clk), .rst_n(rst_n), .in_a(din[2][WC-1:0]), .en(en),
        .out(o_c), .out_q(q_c), .out_valid(v_c), .toggle_cnt(t_c));

    assign dout[0] = 64'(o_a);
    assign dout[1] = 64'(o_b);
    assign dout[2] = 64'(o_c);
    assign dq[0]   = 64'(q_a);
    assign dq[1]   = 64'(q_b);
    assign dq[2]   = 64'(q_c);
    assign dv[0]   = 64'(v_a);
    assign dv[1]   = 64'(v_b);
    assign dv[2]   = 64'(v_c);
    assign dt[0]   = 64'(t_a);
    assign dt[1]   = 64'(t_b);
    assign dt[2]   = 64'(t_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic int unsigned wid(input int i);
        case (i)
            0:       return WA;
            1:       return WB;
            default: return WC;
        endcase
    endfunction

    function automatic int unsigned cw(input int i);
        case (i)
            0:       return CA;
            1:       return CB;
            default: return CC;
        endcase
    endfunction

    function automatic logic [63:0] msk(input int unsigned w);
        if (w >= 64) return '1;
        return (64'(1) << w) - 64'(1);
    endfunction

    // Model state: last sampled input, last input captured with en, number of
    // observed input changes (unbounded), and whether any capture happened.
    logic [63:0] m_prev [3];
    logic [63:0] m_cap  [3];
    int          m_chg  [3];
    logic        m_val  [3];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_prev[i] <= '0;
                m_cap[i]  <= '0;
                m_chg[i]  <= 0;
                m_val[i]  <= 1'b0;
            end else begin
                if ((din[i] & msk(wid(i))) != m_prev[i]) m_chg[i] <= m_chg[i] + 1;
                m_prev[i] <= din[i] & msk(wid(i));
                if (en) begin
                    m_cap[i] <= din[i] & msk(wid(i));
                    m_val[i] <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        longint cmax;
        longint ecnt;
        for (int i = 0; i < 3; i++) begin
            cmax = (longint'(1) << cw(i)) - 1;
            ecnt = (longint'(m_chg[i]) > cmax) ? cmax : longint'(m_chg[i]);
            chk($sformatf("out[%0d]", i),   dout[i], ~din[i] & msk(wid(i)));
            chk($sformatf("out_q[%0d]", i), dq[i],   ~m_cap[i] & msk(wid(i)));
            chk($sformatf("valid[%0d]", i), dv[i],   64'(m_val[i]));
            chk($sformatf("cnt[%0d]", i),   dt[i],   64'(ecnt));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        check_model();
    endtask

    logic [7:0] vec_a [8] = '{8'h00, 8'hFF, 8'hFF, 8'h3C, 8'h3D, 8'h80, 8'h80, 8'h01};
    logic [3:0] vec_c [8] = '{4'h0, 4'hF, 4'h1, 4'h1, 4'h8, 4'h7, 4'h7, 4'h2};
    logic       vec_e [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 3; i++) din[i] = '0;
        #1 rst_n = 1'b0;

        // Reset values reached without a clock edge being needed.
        #10;
        chk("rst_out_b",   dout[1], 64'h1);
        chk("rst_q_b",     dq[1],   64'h1);
        chk("rst_valid_b", dv[1],   64'h0);
        chk("rst_cnt_b",   dt[1],   64'h0);
        chk("rst_q_a",     dq[0],   64'hFF);
        check_model();

        din[1] = 64'h1;
        #10;
        chk("rst_out_b_track", dout[1], 64'h0);
        check_model();

        // Clock edges during reset must not move any register.
        en = 1'b1;
        din[0] = 64'h77;
        repeat (2) tick();
        chk("rst_hold_q_a",   dq[0], 64'hFF);
        chk("rst_hold_cnt_a", dt[0], 64'h0);
        en = 1'b0;
        din[1] = 64'h0;
        din[0] = 64'h0;

        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        din[0] = 64'hA5;
        tick();
        chk("a5_q",     dq[0], 64'h5A);
        chk("a5_valid", dv[0], 64'h1);
        chk("a5_cnt",   dt[0], 64'h1);

        en = 1'b0;
        din[0] = 64'h0F;
        repeat (2) tick();
        chk("hold_q",   dq[0],   64'h5A);
        chk("hold_out", dout[0], 64'hF0);
        chk("hold_cnt", dt[0],   64'h2);
        chk("c_cnt0",   dt[2],   64'h0);

        for (int k = 0; k < 6; k++) begin
            din[2] = (k % 2 == 0) ? 64'h5 : 64'hA;
            tick();
        end
        chk("c_sat", dt[2], 64'h3);

        for (int k = 0; k < 8; k++) begin
            din[0] = 64'(vec_a[k]);
            din[1] = 64'(k % 3 == 0);
            din[2] = 64'(vec_c[k]);
            en     = vec_e[k];
            tick();
        end
        chk("tbl_q_a",   dq[0], 64'h7F);
        chk("tbl_q_c",   dq[2], 64'h8);
        chk("tbl_cnt_c", dt[2], 64'h3);

        // Mid-cycle reset pulse while valid is high.
        #1 rst_n = 1'b0;
        #1;
        chk("mid_valid_a", dv[0],   64'h0);
        chk("mid_q_a",     dq[0],   64'hFF);
        chk("mid_cnt_a",   dt[0],   64'h0);
        chk("mid_out_a",   dout[0], ~din[0] & 64'hFF);
        check_model();
        din[0] = 64'hC3;
        #1;
        chk("mid_out_a2", dout[0], 64'h3C);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        tick();
        chk("post_cnt_a",   dt[0], 64'h1);
        chk("post_valid_a", dv[0], 64'h0);
        en = 1'b1;
        tick();
        chk("post_q_a",     dq[0], 64'h3C);
        chk("post_valid2",  dv[0], 64'h1);
        chk("post_cnt_a2",  dt[0], 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
